// File: rtl/pingpong_bank_sched.sv
// Ping-pong input-buffer scheduler: hands the two SRAM banks to the loader and the array in fill order.
// Optional perf counters (tile_cnt, ld_stall_cnt, ar_stall_cnt) are built when PPB_PERF_CNT_EN is defined.
module pingpong_bank_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             ld_req,
  input  logic             ld_done,
  output logic             ld_grant,
  output logic             loader_bank_sel,
  input  logic             ar_req,
  input  logic             ar_done,
  output logic             ar_grant,
  output logic             array_bank_sel,
  output logic [1:0]       full_cnt,
  output logic             proto_err,
  output logic [CNT_W-1:0] tile_cnt,
  output logic [CNT_W-1:0] ld_stall_cnt,
  output logic [CNT_W-1:0] ar_stall_cnt
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_e;

  bank_st_e bank_st [2];
  logic     wr_ptr, rd_ptr;
  logic     ld_pend, ar_pend;

  logic ld_acc, ar_acc, ld_fin, ar_fin, ld_bad, ar_bad;

  assign ld_acc = ld_req && !ld_grant && !ld_pend && (bank_st[wr_ptr] == EMPTY);
  assign ar_acc = ar_req && !ar_grant && !ar_pend && (bank_st[rd_ptr] == FULL);
  assign ld_fin = ld_done && ld_grant;
  assign ar_fin = ar_done && ar_grant;
  assign ld_bad = ld_done && !ld_grant;
  assign ar_bad = ar_done && !ar_grant;

  // ld_acc only touches an EMPTY bank and ar_fin a DRAINING one (likewise ld_fin/ar_acc),
  // so the two sides never write the same bank entry in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st[0]      <= EMPTY;
      bank_st[1]      <= EMPTY;
      wr_ptr          <= 1'b0;
      rd_ptr          <= 1'b0;
      ld_pend         <= 1'b0;
      ar_pend         <= 1'b0;
      ld_grant        <= 1'b0;
      ar_grant        <= 1'b0;
      loader_bank_sel <= 1'b0;
      array_bank_sel  <= 1'b1;
      full_cnt        <= 2'd0;
      proto_err       <= 1'b0;
    end else if (flush) begin
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      ld_pend    <= 1'b0;
      ar_pend    <= 1'b0;
      ld_grant   <= 1'b0;
      ar_grant   <= 1'b0;
      full_cnt   <= 2'd0;
      proto_err  <= 1'b0;
    end else begin
      // Loader side: select first, grant one cycle later for the SRAM's registered select
      ld_pend <= ld_acc;
      if (ld_acc) begin
        bank_st[wr_ptr] <= FILLING;
        loader_bank_sel <= wr_ptr;
      end
      if (ld_pend) ld_grant <= 1'b1;
      if (ld_fin) begin
        bank_st[wr_ptr] <= FULL;
        wr_ptr          <= ~wr_ptr;
        ld_grant        <= 1'b0;
      end

      ar_pend <= ar_acc;
      if (ar_acc) begin
        bank_st[rd_ptr] <= DRAINING;
        array_bank_sel  <= rd_ptr;
      end
      if (ar_pend) ar_grant <= 1'b1;
      if (ar_fin) begin
        bank_st[rd_ptr] <= EMPTY;
        rd_ptr          <= ~rd_ptr;
        ar_grant        <= 1'b0;
      end

      // Banks holding valid data (FULL or being drained); bounded to 2 by the bank count
      case ({ld_fin, ar_fin})
        2'b10:   full_cnt <= full_cnt + 2'd1;
        2'b01:   full_cnt <= full_cnt - 2'd1;
        default: full_cnt <= full_cnt;
      endcase

      proto_err <= proto_err | ld_bad | ar_bad;
    end
  end

`ifdef PPB_PERF_CNT_EN
  logic ld_stall, ar_stall;

  // A request waiting out its pend cycle or already granted is not a stall
  assign ld_stall = ld_req && !ld_grant && !ld_pend && !ld_acc;
  assign ar_stall = ar_req && !ar_grant && !ar_pend && !ar_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_cnt     <= '0;
      ld_stall_cnt <= '0;
      ar_stall_cnt <= '0;
    end else if (!flush) begin
      if (ar_fin && (tile_cnt != '1))       tile_cnt     <= tile_cnt + 1'b1;
      if (ld_stall && (ld_stall_cnt != '1)) ld_stall_cnt <= ld_stall_cnt + 1'b1;
      if (ar_stall && (ar_stall_cnt != '1)) ar_stall_cnt <= ar_stall_cnt + 1'b1;
    end
  end
`else
  assign tile_cnt     = '0;
  assign ld_stall_cnt = '0;
  assign ar_stall_cnt = '0;
`endif

endmodule
